// File: rtl/pc_gen.sv
// pc_gen: IF-stage program-counter generator.
// Holds the fetch PC and offers it to instruction memory over a valid/ready handshake.
// Redirect priority: exception > eret > branch > sequential.
// A branch that arrives while the fetch is stalled or backpressured is parked until the next accept.
// Optional build macro PC_TRACE_EN adds a circular trace buffer of accepted PCs.
//
// state | meaning
// BOOT  | first cycle after reset release; pc_valid still low
// RUN   | fetching; no branch parked
// PEND  | fetching; a branch target is parked awaiting accept
module pc_gen #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] EXC_VEC     = WIDTH'(32'h0000_4180),
    parameter int               INC         = 4,
    parameter int               TRACE_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           pcwe,
    input  logic                           pc_ready,
    input  logic                           br_valid,
    input  logic [WIDTH-1:0]               br_target,
    input  logic                           exc_valid,
    input  logic                           eret_valid,
    input  logic [WIDTH-1:0]               epc,
    output logic [WIDTH-1:0]               pc_out,
    output logic                           pc_valid,
    output logic                           pc_misalign,
`ifdef PC_TRACE_EN
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [WIDTH-1:0]               trace_pc,
    output logic [$clog2(TRACE_DEPTH):0]   trace_cnt,
`endif
    output logic                           pend_valid
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pend_target;
    logic [WIDTH-1:0] pc_nxt;
    logic             acc;
    logic             active;

    // Trace depth must be a non-zero power of two for the pointer arithmetic to wrap correctly.
    if (TRACE_DEPTH < 1 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pc_gen: TRACE_DEPTH must be a power of two");
    end

    assign acc    = pc_valid & pc_ready & pcwe;
    assign active = (state == RUN) || (state == PEND);

    // Next-PC selection; exc/eret kill the outstanding fetch even when stalled or backpressured.
    always_comb begin
        pc_nxt = pc_out;
        if (active) begin
            if (exc_valid)
                pc_nxt = EXC_VEC;
            else if (eret_valid)
                pc_nxt = epc;
            else if (acc && br_valid)
                pc_nxt = br_target;
            else if (acc && (state == PEND))
                pc_nxt = pend_target;
            else if (acc)
                pc_nxt = pc_out + WIDTH'(INC);
        end
    end

    // Sequencer: registers the PC, its misalignment flag, and the parked-branch state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc_out      <= RESET_PC;
            pc_valid    <= 1'b0;
            pc_misalign <= (RESET_PC[1:0] != 2'b00);
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else begin
            pc_out      <= pc_nxt;
            pc_misalign <= (pc_nxt[1:0] != 2'b00);
            case (state)
                BOOT: begin
                    state    <= RUN;
                    pc_valid <= 1'b1;
                end
                RUN, PEND: begin
                    if (exc_valid || eret_valid || acc) begin
                        state      <= RUN;
                        pend_valid <= 1'b0;
                    end else if (br_valid) begin
                        // youngest branch wins if one is already parked
                        state       <= PEND;
                        pend_valid  <= 1'b1;
                        pend_target <= br_target;
                    end
                end
                default: begin
                    state      <= BOOT;
                    pc_valid   <= 1'b0;
                    pend_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_TRACE_EN
    localparam int            TW      = $clog2(TRACE_DEPTH);
    localparam logic [TW:0]   CNT_MAX = (TW + 1)'(TRACE_DEPTH);

    logic [WIDTH-1:0] trace_mem [TRACE_DEPTH];
    logic [TW-1:0]    trace_ptr;

    // Write pointer and saturating fill count of the trace buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trace_ptr <= '0;
            trace_cnt <= '0;
        end else if (acc) begin
            trace_ptr <= trace_ptr + TW'(1);
            if (trace_cnt != CNT_MAX)
                trace_cnt <= trace_cnt + (TW + 1)'(1);
        end
    end

    // Trace storage; contents are only meaningful below trace_cnt, so no reset is needed.
    always_ff @(posedge clk) begin
        if (acc)
            trace_mem[trace_ptr] <= pc_out;
    end

    // Index 0 is the newest entry, one slot behind the write pointer.
    assign trace_pc = trace_mem[trace_ptr - TW'(1) - trace_idx];
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus randomized redirect/stall traffic,
// checked through an expected-response queue against a rule-level reference model.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pcwe = 1'b0;
    logic        pc_ready = 1'b0;
    logic        br_valid = 1'b0;
    logic        exc_valid = 1'b0;
    logic        eret_valid = 1'b0;
    logic [31:0] br_target = '0;
    logic [31:0] epc = '0;
    logic [31:0] pc_out;
    logic        pc_valid, pc_misalign, pend_valid;

    logic [31:0] pc2;
    logic        v2, mis2, pend2;
`ifdef PC_TRACE_EN
    logic [2:0]  trace_idx = '0;
    logic [31:0] trace_pc;
    logic [3:0]  trace_cnt;
    logic [2:0]  tidx2 = '0;
    logic [31:0] tpc2;
    logic [3:0]  tcnt2;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk(clk), .rst_n(rst_n), .pcwe(pcwe), .pc_ready(pc_ready),
        .br_valid(br_valid), .br_target(br_target),
        .exc_valid(exc_valid), .eret_valid(eret_valid), .epc(epc),
        .pc_out(pc_out), .pc_valid(pc_valid), .pc_misalign(pc_misalign),
`ifdef PC_TRACE_EN
        .trace_idx(trace_idx), .trace_pc(trace_pc), .trace_cnt(trace_cnt),
`endif
        .pend_valid(pend_valid)
    );

    // Second instance exercises a reset PC near the top of the address space.
    pc_gen #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst_n(rst_n), .pcwe(1'b1), .pc_ready(1'b1),
        .br_valid(1'b0), .br_target(32'h0),
        .exc_valid(1'b0), .eret_valid(1'b0), .epc(32'h0),
        .pc_out(pc2), .pc_valid(v2), .pc_misalign(mis2),
`ifdef PC_TRACE_EN
        .trace_idx(tidx2), .trace_pc(tpc2), .trace_cnt(tcnt2),
`endif
        .pend_valid(pend2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic        pend;
        logic        mis;
    } exp_t;

    exp_t        expq[$];
    bit   [31:0] m_pc = 32'h3000;
    bit          m_valid = 1'b0;
    bit          m_pend = 1'b0;
    bit   [31:0] m_tgt = '0;
    bit   [31:0] m_trace[$];

    always @(posedge clk or negedge rst_n) begin
        bit   take;
        exp_t e;
        if (!rst_n) begin
            m_pc    = 32'h3000;
            m_valid = 1'b0;
            m_pend  = 1'b0;
            m_trace.delete();
            expq.delete();
        end else begin
            take = m_valid && pc_ready && pcwe;
            if (!m_valid) begin
                m_valid = 1'b1;
            end else begin
                if (take) begin
                    m_trace.push_front(m_pc);
                    if (m_trace.size() > 8) void'(m_trace.pop_back());
                end
                if (exc_valid) begin
                    m_pc = 32'h4180; m_pend = 1'b0;
                end else if (eret_valid) begin
                    m_pc = epc; m_pend = 1'b0;
                end else if (take && br_valid) begin
                    m_pc = br_target; m_pend = 1'b0;
                end else if (take && m_pend) begin
                    m_pc = m_tgt; m_pend = 1'b0;
                end else if (take) begin
                    m_pc = m_pc + 32'd4;
                end else if (br_valid) begin
                    m_pend = 1'b1; m_tgt = br_target;
                end
            end
            e.pc   = m_pc;
            e.pend = m_pend;
            e.mis  = (m_pc % 4) != 0;
            expq.push_back(e);
        end
    end

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && pc_valid) begin
            chk("expq_avail", 32'(expq.size() != 0), 32'd1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("pc", pc_out, e.pc);
                chk("pend", 32'(pend_valid), 32'(e.pend));
                chk("misalign", 32'(pc_misalign), 32'(e.mis));
`ifdef PC_TRACE_EN
                chk("trace_cnt", 32'(trace_cnt), 32'(m_trace.size()));
                if (int'(trace_idx) < m_trace.size())
                    chk("trace_pc", trace_pc, m_trace[trace_idx]);
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit we, input bit rdy, input bit br, input bit [31:0] bt,
                       input bit ex, input bit er, input bit [31:0] ep);
        pcwe       = we;
        pc_ready   = rdy;
        br_valid   = br;
        br_target  = bt;
        exc_valid  = ex;
        eret_valid = er;
        epc        = ep;
`ifdef PC_TRACE_EN
        trace_idx  = 3'($urandom_range(0, 7));
`endif
        @(negedge clk);
    endtask

    initial begin
        bit [31:0] bt, ep;
        bit [31:0] last;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc_out, 32'h3000);
        chk("rst_valid", 32'(pc_valid), 32'd0);
        chk("rst_pend", 32'(pend_valid), 32'd0);
        chk("rst_mis", 32'(pc_misalign), 32'd0);
        chk("rst_pc2", pc2, 32'hFFFF_FFF8);
        chk("rst_valid2", 32'(v2), 32'd0);

        rst_n = 1'b1;
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("boot_pc", pc_out, 32'h3000);
        chk("boot_valid", 32'(pc_valid), 32'd1);
        chk("wrap_pc0", pc2, 32'hFFFF_FFF8);
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("seq_3004", pc_out, 32'h3004);
        chk("wrap_pc1", pc2, 32'hFFFF_FFFC);
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("seq_3008", pc_out, 32'h3008);
        chk("wrap_pc2", pc2, 32'h0000_0000);
        chk("wrap_mis", 32'(mis2), 32'd0);

        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 0, 0, 0);
            chk("stall_hold", pc_out, 32'h3008);
        end
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("resume_300c", pc_out, 32'h300C);

        cyc(0, 1, 1, 32'h3100, 0, 0, 0);
        chk("br_park_pend", 32'(pend_valid), 32'd1);
        chk("br_park_pc", pc_out, 32'h300C);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("br_still_pend", 32'(pend_valid), 32'd1);
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("br_taken_pc", pc_out, 32'h3100);
        chk("br_taken_pend", 32'(pend_valid), 32'd0);

        cyc(0, 1, 1, 32'h3200, 0, 0, 0);
        chk("br2_pend", 32'(pend_valid), 32'd1);
        cyc(0, 0, 1, 32'h3300, 1, 0, 0);
        chk("exc_pc", pc_out, 32'h4180);
        chk("exc_pend", 32'(pend_valid), 32'd0);
        cyc(0, 0, 0, 0, 0, 1, 32'h3100);
        chk("eret_pc", pc_out, 32'h3100);

        cyc(1, 1, 1, 32'h3102, 0, 0, 0);
        chk("mis_pc", pc_out, 32'h3102);
        chk("mis_flag", 32'(pc_misalign), 32'd1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("bp_hold", pc_out, 32'h3102);
        cyc(1, 0, 1, 32'h3400, 0, 0, 0);
        chk("bp_br_hold", pc_out, 32'h3102);
        chk("bp_br_pend", 32'(pend_valid), 32'd1);
        cyc(1, 0, 1, 32'h3500, 1, 1, 32'h3600);
        chk("exc_over_eret", pc_out, 32'h4180);

        for (int i = 0; i < 2000; i++) begin
            bt = $urandom & 32'hFFFF_FFFC;
            ep = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) bt[1:0] = 2'($urandom_range(1, 3));
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 4) == 0, bt,
                $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, ep);
        end

        last = '0;
        for (int i = 0; i < 10; i++) begin
            last = m_pc;
            cyc(1, 1, 0, 0, 0, 0, 0);
        end
        chk("seq_after_10", pc_out, last + 32'd4);
`ifdef PC_TRACE_EN
        chk("trace_full", 32'(trace_cnt), 32'd8);
        trace_idx = 3'd0;
        #1;
        chk("trace_newest", trace_pc, last);
`endif

        chk("expq_left", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
